button_conditioner: RTL and testbench
=====================================

# button_conditioner

Input conditioning stage that sits directly upstream of the WAIT stage in the Simon Says game. It synchronises the four raw colour buttons, debounces press and release, rejects chords, and emits exactly one single-cycle `press_valid` pulse with a 2-bit colour code per confirmed press. This replaces the raw OR of `ui_in[3:0]` and the combinational decoder as the source of `colour_in`/`colour_val` for WAIT.

## Interface
Parameters:
- `DEBOUNCE_CYCLES`, default 16: number of consecutive stable synchronised samples required to confirm a press or a release. Legal range is 2..255.
- `CNT_W`, default 8: debounce counter width. Must satisfy 2^CNT_W > DEBOUNCE_CYCLES.

Ports:
- `clk`, input, 1: system clock. The block uses this single clock only.
- `rst`, input, 1: synchronous, active-high reset.
- `btn_raw`, input, 4: asynchronous button levels (`ui_in[3:0]`), active high.
- `en`, input, 1: press reporting enable (driven by WAIT's enable). When low, `press_valid` and `press_err` are suppressed; the FSM still runs.
- `press_valid`, output, 1: one-cycle pulse marking a confirmed single-button press.
- `press_colour`, output, 2: colour code. It is valid when `press_valid` is high and holds its value otherwise.
- `press_err`, output, 1: one-cycle pulse marking a confirmed chord (more than one button).
- `btn_busy`, output, 1: high in every state except IDLE. Used for debug on `uo_out`.

## Operation
Synchroniser:
- Each bit of `btn_raw` passes through a 2-flop synchroniser to produce `sync[3:0]`.

Colour map (one-hot to code):
- bit0→0, bit1→1, bit2→2, bit3→3.

FSM states, registered pattern `pat[3:0]`, and counter `cnt`:
- **IDLE**: if `sync != 0`, set `pat<=sync`, `cnt<=0`, and go to PRESS_DB.
- **PRESS_DB**:
  - If `sync == 0`, go to IDLE.
  - Else if `sync != pat`, set `pat<=sync` and `cnt<=0` (restart, stay).
  - Else if `cnt == DEBOUNCE_CYCLES-1`, go to HELD. In the same edge:
    - if `pat` is one-hot, register `press_valid<=en` and set `press_colour` from `pat`;
    - otherwise register `press_err<=en`.
  - Otherwise `cnt<=cnt+1`.
- **HELD**: if `sync == 0`, set `cnt<=0` and go to REL_DB. Any change of nonzero pattern while held is ignored.
- **REL_DB**:
  - If `sync != 0`, go to HELD. No new pulse is generated.
  - Else if `cnt == DEBOUNCE_CYCLES-1`, go to IDLE.
  - Otherwise `cnt<=cnt+1`.

Rules:
- At most one pulse (`press_valid` xor `press_err`) is generated per press/release cycle.
- A new press is only recognised after a full debounced release.
- `en` is sampled only on the confirming edge. A press confirmed while `en=0` is consumed silently and never reported later.
- `cnt` never wraps, because it is bounded by `DEBOUNCE_CYCLES-1`.

## Timing
Reset values:
- `rst` high on an edge returns the block to IDLE.
- All outputs go to 0: `press_valid`, `press_colour=2'b00`, `press_err`, `btn_busy`.
- `pat`, `cnt` and the synchroniser flops are all cleared.

Mid-press reset:
- `rst` during a press returns the block to IDLE. If the button is still down after reset releases, it is seen as a new press.

Latency:
- `btn_raw` stable from before edge 1 gives `sync` valid after edge 2.
- The FSM enters PRESS_DB at edge 3.
- `press_valid` goes high after edge `DEBOUNCE_CYCLES+3` and lasts exactly one cycle.

Release:
- From `btn_raw` falling, the FSM returns to IDLE after `DEBOUNCE_CYCLES+3` edges.

Glitches:
- A glitch shorter than `DEBOUNCE_CYCLES` samples produces no pulse.

Simultaneous `rst` and confirm:
- Reset wins, and no pulse is generated.

## Structure
- Shared package `simon_pkg`:
  - localparams `COLOUR_0..COLOUR_3` (2'd0..2'd3);
  - state encoding `ST_IDLE`, `ST_PRESS_DB`, `ST_HELD`, `ST_REL_DB` (2 bits);
  - function `onehot_to_colour`. The existing `colour_decoder` should migrate to this function.
- Sub-module: `sync_2ff`, a parameterised-width 2-flop synchroniser with synchronous active-high `rst`.
- The FSM, counter and output registers stay in `button_conditioner`.

## Test plan
All scenarios use `DEBOUNCE_CYCLES=4`.
1. **Single press:** `en=1`, `btn_raw=4'b0100` held for 20 cycles, then 0. Expect:
   - exactly one `press_valid`, high after edge 7, with `press_colour=2`;
   - `btn_busy` returns to 0 seven edges after release.
2. **Bounce:** `btn_raw=4'b0001` toggled 0/1 every 2 cycles for 12 cycles, then steady for 10 cycles. Expect exactly one `press_valid`, with colour 0, 7 edges after the steady level begins.
3. **Chord:** `btn_raw=4'b1010` held. Expect one `press_err` and no `press_valid`.
4. **Press during disabled window:** `btn_raw=4'b1000` pressed with `en=0`, and `en` raised while the button is still held. Expect no pulse ever. A subsequent clean press/release with `en=1` yields `press_valid` with colour 3.
5. **Reset mid-press:** `rst` pulsed during PRESS_DB with the button still held. Expect outputs 0 during reset, then a fresh `press_valid` `DEBOUNCE_CYCLES+3` edges after `rst` falls.
6. **Short release glitch:** release pulse of 2 cycles while HELD. Expect no second `press_valid`, and `btn_busy` stays 1.

Source files
------------

// File: rtl/simon_pkg.sv
// Shared definitions for the Simon Says datapath: colour codes, the
// button conditioner state encoding and the one-hot colour helpers.
package simon_pkg;

    localparam logic [1:0] COLOUR_0 = 2'd0;
    localparam logic [1:0] COLOUR_1 = 2'd1;
    localparam logic [1:0] COLOUR_2 = 2'd2;
    localparam logic [1:0] COLOUR_3 = 2'd3;

    localparam int NUM_BTN = 4;

    typedef enum logic [1:0] {
        ST_IDLE     = 2'd0,
        ST_PRESS_DB = 2'd1,
        ST_HELD     = 2'd2,
        ST_REL_DB   = 2'd3
    } btn_state_t;

    // Lowest set bit wins; callers only pass one-hot values, so the
    // priority only matters for keeping the function total.
    function automatic logic [1:0] onehot_to_colour(input logic [NUM_BTN-1:0] oh);
        logic [1:0] c;
        c = COLOUR_0;
        if (oh[3]) c = COLOUR_3;
        if (oh[2]) c = COLOUR_2;
        if (oh[1]) c = COLOUR_1;
        if (oh[0]) c = COLOUR_0;
        return c;
    endfunction

    // True when exactly one button is down.
    function automatic logic is_onehot(input logic [NUM_BTN-1:0] v);
        return (v != '0) && ((v & (v - 1'b1)) == '0);
    endfunction

endpackage

// File: rtl/sync_2ff.sv
// Two-flop synchroniser for asynchronous level inputs, one chain per bit.
module sync_2ff #(
    parameter int WIDTH = 4
) (
    input  logic             clk,
    input  logic             rst,
    input  logic [WIDTH-1:0] d,
    output logic [WIDTH-1:0] q
);

    logic [WIDTH-1:0] meta;

    // First stage may go metastable; second stage gives it a cycle to settle.
    always_ff @(posedge clk) begin
        if (rst) begin
            meta <= '0;
            q    <= '0;
        end else begin
            meta <= d;
            q    <= meta;
        end
    end

endmodule

// File: rtl/button_conditioner.sv
// Synchronises, debounces and chord-checks the four colour buttons and
// emits one pulse per confirmed press for the WAIT stage.
module button_conditioner
    import simon_pkg::*;
#(
    parameter int DEBOUNCE_CYCLES = 16,
    parameter int CNT_W           = 8
) (
    input  logic         clk,
    input  logic         rst,
    input  logic [3:0]   btn_raw,
    input  logic         en,
    output logic         press_valid,
    output logic [1:0]   press_colour,
    output logic         press_err,
    output logic         btn_busy
);

    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(DEBOUNCE_CYCLES - 1);

    logic [3:0]       sync;
    btn_state_t       state_q, state_d;
    logic [3:0]       pat_q, pat_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic             valid_d, err_d;
    logic [1:0]       colour_d;

    sync_2ff #(.WIDTH(4)) u_sync (
        .clk (clk),
        .rst (rst),
        .d   (btn_raw),
        .q   (sync)
    );

    // Next-state, debounce counter and pulse generation.
    always_comb begin
        state_d  = state_q;
        pat_d    = pat_q;
        cnt_d    = cnt_q;
        valid_d  = 1'b0;
        err_d    = 1'b0;
        colour_d = press_colour;
        case (state_q)
            ST_IDLE: begin
                if (sync != 4'd0) begin
                    pat_d   = sync;
                    cnt_d   = '0;
                    state_d = ST_PRESS_DB;
                end
            end
            ST_PRESS_DB: begin
                if (sync == 4'd0) begin
                    state_d = ST_IDLE;
                end else if (sync != pat_q) begin
                    // Pattern moved (bounce or a second finger): start over.
                    pat_d = sync;
                    cnt_d = '0;
                end else if (cnt_q == CNT_LAST) begin
                    state_d = ST_HELD;
                    // en is only looked at here, so a press confirmed while
                    // disabled is swallowed rather than reported late.
                    if (is_onehot(pat_q)) begin
                        valid_d  = en;
                        colour_d = onehot_to_colour(pat_q);
                    end else begin
                        err_d = en;
                    end
                end else begin
                    cnt_d = cnt_q + 1'b1;
                end
            end
            ST_HELD: begin
                if (sync == 4'd0) begin
                    cnt_d   = '0;
                    state_d = ST_REL_DB;
                end
            end
            ST_REL_DB: begin
                if (sync != 4'd0) begin
                    // Release was a glitch; back to held without a new pulse.
                    state_d = ST_HELD;
                end else if (cnt_q == CNT_LAST) begin
                    state_d = ST_IDLE;
                end else begin
                    cnt_d = cnt_q + 1'b1;
                end
            end
            default: state_d = ST_IDLE;
        endcase
    end

    // State, pattern, counter and registered outputs; reset beats a confirm.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q      <= ST_IDLE;
            pat_q        <= '0;
            cnt_q        <= '0;
            press_valid  <= 1'b0;
            press_err    <= 1'b0;
            press_colour <= COLOUR_0;
        end else begin
            state_q      <= state_d;
            pat_q        <= pat_d;
            cnt_q        <= cnt_d;
            press_valid  <= valid_d;
            press_err    <= err_d;
            press_colour <= colour_d;
        end
    end

    assign btn_busy = (state_q != ST_IDLE);

endmodule

// File: tb/tb_button_conditioner.sv
// Bench for button_conditioner with DEBOUNCE_CYCLES=4: expected pulses are
// queued when stimulus is driven and matched by a monitor on falling edges.
module tb_button_conditioner;

    localparam int D   = 4;
    localparam int LAT = D + 3;

    typedef struct {
        bit         err;
        logic [1:0] colour;
        int         cyc;
    } exp_t;

    logic       clk = 1'b0;
    logic       rst;
    logic [3:0] btn_raw;
    logic       en;
    logic       press_valid;
    logic [1:0] press_colour;
    logic       press_err;
    logic       btn_busy;

    int   cyc = 0;
    int   tests_run = 0;
    int   tests_failed = 0;
    exp_t sb_q[$];
    exp_t mon_e;

    button_conditioner #(.DEBOUNCE_CYCLES(D), .CNT_W(8)) dut (
        .clk          (clk),
        .rst          (rst),
        .btn_raw      (btn_raw),
        .en           (en),
        .press_valid  (press_valid),
        .press_colour (press_colour),
        .press_err    (press_err),
        .btn_busy     (btn_busy)
    );

    always #5 clk = ~clk;

    // Edge counter: after posedge k, cyc == k.
    always @(posedge clk) cyc <= cyc + 1;

    // Scoreboard monitor: every pulse must match the head of the queue.
    always @(negedge clk) begin
        if (press_valid || press_err) begin
            tests_run++;
            if (press_valid && press_err) begin
                tests_failed++;
                $display("FAIL both_pulses cyc=%0d valid=%b err=%b, need only one", cyc, press_valid, press_err);
            end else if (sb_q.size() == 0) begin
                tests_failed++;
                $display("FAIL unexpected_pulse cyc=%0d valid=%b err=%b colour=%0d, need no pulse",
                         cyc, press_valid, press_err, press_colour);
            end else begin
                mon_e = sb_q.pop_front();
                if (press_err !== mon_e.err || cyc != mon_e.cyc ||
                    (!mon_e.err && press_colour !== mon_e.colour)) begin
                    tests_failed++;
                    $display("FAIL pulse_match got err=%b colour=%0d cyc=%0d, need err=%b colour=%0d cyc=%0d",
                             press_err, press_colour, cyc, mon_e.err, mon_e.colour, mon_e.cyc);
                end
            end
        end
    end

    task automatic push_exp(input bit err, input logic [1:0] colour, input int at);
        exp_t e;
        e.err = err; e.colour = colour; e.cyc = at;
        sb_q.push_back(e);
    endtask

    task automatic tick(input int n);
        repeat (n) @(negedge clk);
    endtask

    // Bounded wait for the FSM to return to IDLE.
    task automatic wait_idle(input string name);
        for (int i = 0; i < 40; i++) begin
            @(negedge clk);
            if (!btn_busy) break;
        end
        tests_run++;
        if (btn_busy !== 1'b0) begin
            tests_failed++;
            $display("FAIL %s_idle_timeout btn_busy=%b, need 0 within 40 cycles", name, btn_busy);
        end
    endtask

    task automatic test_reset();
        rst = 1'b1; en = 1'b1; btn_raw = 4'b0101;
        tick(3);
        tests_run++;
        if ({press_valid, press_err, press_colour, btn_busy} !== 5'b0) begin
            tests_failed++;
            $display("FAIL reset_outputs got v=%b e=%b c=%0d busy=%b, need all 0",
                     press_valid, press_err, press_colour, btn_busy);
        end
        btn_raw = 4'b0000;
        rst = 1'b0;
        tick(4);
        tests_run++;
        if (btn_busy !== 1'b0) begin
            tests_failed++;
            $display("FAIL reset_idle btn_busy=%b, need 0", btn_busy);
        end
    endtask

    task automatic test_single_press();
        int r;
        en = 1'b1;
        btn_raw = 4'b0100;
        push_exp(1'b0, 2'd2, cyc + LAT);
        tick(20);
        btn_raw = 4'b0000;
        r = cyc;
        tick(LAT - 1);
        tests_run++;
        if (btn_busy !== 1'b1) begin
            tests_failed++;
            $display("FAIL single_busy_before_idle cyc=%0d busy=%b, need 1", cyc - r, btn_busy);
        end
        tick(1);
        tests_run++;
        if (btn_busy !== 1'b0) begin
            tests_failed++;
            $display("FAIL single_release_latency busy=%b at release+%0d, need 0", btn_busy, cyc - r);
        end
        tests_run++;
        if (sb_q.size() != 0) begin
            tests_failed++;
            $display("FAIL single_missing_pulse pending=%0d, need 0", sb_q.size());
        end
    endtask

    task automatic test_bounce();
        en = 1'b1;
        repeat (3) begin
            btn_raw = 4'b0001; tick(2);
            btn_raw = 4'b0000; tick(2);
        end
        btn_raw = 4'b0001;
        push_exp(1'b0, 2'd0, cyc + LAT);
        tick(10);
        btn_raw = 4'b0000;
        wait_idle("bounce");
        tests_run++;
        if (sb_q.size() != 0) begin
            tests_failed++;
            $display("FAIL bounce_missing_pulse pending=%0d, need 0", sb_q.size());
        end
    endtask

    task automatic test_chord();
        en = 1'b1;
        btn_raw = 4'b1010;
        push_exp(1'b1, 2'd0, cyc + LAT);
        tick(12);
        btn_raw = 4'b0000;
        wait_idle("chord");
        tests_run++;
        if (sb_q.size() != 0) begin
            tests_failed++;
            $display("FAIL chord_missing_err pending=%0d, need 0", sb_q.size());
        end
    endtask

    task automatic test_disabled();
        en = 1'b0;
        btn_raw = 4'b1000;
        tick(10);
        en = 1'b1;
        tick(6);
        tests_run++;
        if (btn_busy !== 1'b1) begin
            tests_failed++;
            $display("FAIL disabled_held busy=%b, need 1", btn_busy);
        end
        btn_raw = 4'b0000;
        wait_idle("disabled");
        btn_raw = 4'b1000;
        push_exp(1'b0, 2'd3, cyc + LAT);
        tick(10);
        btn_raw = 4'b0000;
        wait_idle("enabled");
        tests_run++;
        if (sb_q.size() != 0) begin
            tests_failed++;
            $display("FAIL disabled_followup_missing pending=%0d, need 0", sb_q.size());
        end
    endtask

    task automatic test_reset_mid();
        int r;
        en = 1'b1;
        btn_raw = 4'b0010;
        tick(4);
        tests_run++;
        if (btn_busy !== 1'b1) begin
            tests_failed++;
            $display("FAIL midrst_in_press_db busy=%b, need 1", btn_busy);
        end
        rst = 1'b1;
        for (int i = 0; i < 2; i++) begin
            tick(1);
            tests_run++;
            if ({press_valid, press_err, press_colour, btn_busy} !== 5'b0) begin
                tests_failed++;
                $display("FAIL midrst_outputs got v=%b e=%b c=%0d busy=%b, need all 0",
                         press_valid, press_err, press_colour, btn_busy);
            end
        end
        rst = 1'b0;
        r = cyc;
        push_exp(1'b0, 2'd1, r + LAT);
        tick(10);
        btn_raw = 4'b0000;
        wait_idle("midrst");
        tests_run++;
        if (sb_q.size() != 0) begin
            tests_failed++;
            $display("FAIL midrst_fresh_press_missing pending=%0d, need 0", sb_q.size());
        end
    endtask

    task automatic test_rst_confirm();
        en = 1'b1;
        btn_raw = 4'b0001;
        tick(LAT - 1);
        rst = 1'b1;
        btn_raw = 4'b0000;
        tick(1);
        tests_run++;
        if ({press_valid, btn_busy, press_colour} !== 4'b0) begin
            tests_failed++;
            $display("FAIL rst_confirm got v=%b busy=%b c=%0d, need all 0", press_valid, btn_busy, press_colour);
        end
        rst = 1'b0;
        tick(10);
        tests_run++;
        if (btn_busy !== 1'b0) begin
            tests_failed++;
            $display("FAIL rst_confirm_idle busy=%b, need 0", btn_busy);
        end
    endtask

    task automatic test_glitch();
        en = 1'b1;
        btn_raw = 4'b0100;
        push_exp(1'b0, 2'd2, cyc + LAT);
        tick(10);
        btn_raw = 4'b0000;
        tick(2);
        btn_raw = 4'b0100;
        for (int i = 0; i < 10; i++) begin
            tick(1);
            tests_run++;
            if (btn_busy !== 1'b1) begin
                tests_failed++;
                $display("FAIL glitch_busy step=%0d busy=%b, need 1", i, btn_busy);
            end
        end
        btn_raw = 4'b0000;
        wait_idle("glitch");
        tests_run++;
        if (sb_q.size() != 0) begin
            tests_failed++;
            $display("FAIL glitch_first_pulse_missing pending=%0d, need 0", sb_q.size());
        end
    endtask

    initial begin
        rst = 1'b1; en = 1'b0; btn_raw = 4'b0000;
        @(negedge clk);
        test_reset();
        test_single_press();
        test_bounce();
        test_chord();
        test_disabled();
        test_reset_mid();
        test_rst_confirm();
        test_glitch();
        tick(5);
        $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
        $finish;
    end

    initial begin
        #100000;
        $display("FAIL global_timeout cyc=%0d, need finish before limit", cyc);
        $fatal(1, "timeout");
    end

endmodule
